ram_burst_ctrl: RTL
===================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width.
REQ-002 SHALL have parameter ADR_W, default 3, address width; depth = 2^ADR_W (8).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_rd  input  1  0 = burst write, 1 = burst read.
REQ-008 SHALL have port cmd_adr  input  ADR_W  burst start address.
REQ-009 SHALL have port cmd_len  input  ADR_W  burst length minus one (0..7 = 1..8 words).
REQ-010 SHALL have port wr_data  input  DATA_W  write stream data.
REQ-011 SHALL have port wr_valid  input  1  write stream word offered.
REQ-012 SHALL have port wr_ready  output  1  write stream word accepted.
REQ-013 SHALL have port rd_data  output  DATA_W  read stream data, registered.
REQ-014 SHALL have port rd_valid  output  1  read stream word offered, registered.
REQ-015 SHALL have port rd_ready  input  1  read stream consumer ready.
REQ-016 SHALL have port busy  output  1  burst in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse on final word of a burst.
REQ-018 SHALL have ports ram_w (output, 1), ram_adr (output, ADR_W), ram_din (output, DATA_W), ram_dout (input, DATA_W) driving the downstream 8x8 RAM (registered read, data_out updates only on w=0 edges).

Function
REQ-019 SHALL implement FSM states IDLE, WR, RD_REQ, RD_CAP, RD_OUT.
REQ-020 IDLE: cmd_ready=1; on cmd_valid latch cur_adr=cmd_adr, len=cmd_len, cnt=0; go WR if cmd_rd=0 else RD_REQ.
REQ-021 WR: wr_ready=1; on wr_valid, ram_w=1, ram_adr=cur_adr, ram_din=wr_data combinationally in the same cycle.
REQ-022 WR: each accepted word increments cur_adr modulo 2^ADR_W (7 wraps to 0) and cnt; word with cnt==len pulses done, returns to IDLE.
REQ-023 RD_REQ: ram_w=0, ram_adr=cur_adr for exactly one cycle; next state RD_CAP.
REQ-024 RD_CAP: rd_data<=ram_dout, rd_valid<=1 at end of cycle; next state RD_OUT.
REQ-025 RD_OUT: hold rd_data/rd_valid stable until rd_ready=1; on handshake rd_valid<=0.
REQ-026 RD_OUT handshake with cnt==len: pulse done, go IDLE; else increment cur_adr (modulo, wraps) and cnt, go RD_REQ.
REQ-027 Read latency: rd_valid first high 3 cycles after cmd acceptance edge; with rd_ready held high, one word per 3 cycles.
REQ-028 ram_w SHALL be 1 only in WR with wr_valid=1; 0 in all other states.
REQ-029 ram_adr SHALL equal cur_adr in all states; ram_din SHALL equal wr_data at all times.
REQ-030 cmd_ready=1 only in IDLE; wr_ready=1 only in WR; cmd_valid outside IDLE ignored, wr_valid outside WR ignored.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 done asserted combinationally during the final handshake cycle only, never in IDLE.
REQ-033 cmd_len=0 SHALL perform a single-word transfer.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, cur_adr=0, cnt=0, len=0, rd_valid=0, rd_data=0.
REQ-035 While rst=1: cmd_ready=0, wr_ready=0, ram_w=0, busy=0, done=0.
REQ-036 rst mid-burst SHALL abort the burst immediately; no further RAM writes, no done pulse; RAM contents untouched by this block.

Verification
REQ-037 Write adr=2, len=3, data 0x11,0x22,0x33,0x44 with wr_valid high -> ram_w high 4 cycles at adr 2,3,4,5; done on 4th; cmd_ready next cycle.
REQ-038 Read adr=2, len=3, rd_ready high -> rd_data 0x11,0x22,0x33,0x44; first rd_valid 3 cycles after accept; 3-cycle spacing; done on 4th handshake.
REQ-039 Write adr=6, len=3, data 0xA0..0xA3 -> writes at adr 6,7,0,1 (wrap); read back same order returns 0xA0..0xA3.
REQ-040 Read len=0 with rd_ready low 5 cycles after rd_valid -> rd_data/rd_valid stable 5 cycles; single handshake; done once.
REQ-041 Write stream with wr_valid gaps (1 on, 2 off) -> ram_w only on valid cycles; addresses contiguous; done on last word.
REQ-042 rst asserted on 2nd word of an 8-word write -> next cycle IDLE, busy=0, rd_valid=0; only 1st word written; new command accepted after rst release.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a small registered-read RAM.
// A command sets a start address and a length. A write burst streams words from the
// wr_* handshake into the RAM. A read burst issues one RAM read per word, captures
// the result, and offers it on the rd_* handshake.
module ram_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADR_W-1:0]  cmd_adr,
  input  logic [ADR_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_w,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD_REQ = 3'd2,
    RD_CAP = 3'd3,
    RD_OUT = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADR_W-1:0]  cur_adr, cur_adr_nxt;
  logic [ADR_W-1:0]  len, len_nxt;
  logic [ADR_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] rd_data_nxt;
  logic              rd_valid_nxt;

  // The address always follows the burst pointer, and the write data passes straight through.
  // A read is therefore requested on every cycle that ram_w is low.
  assign ram_adr = cur_adr;
  assign ram_din = wr_data;
  assign busy    = (state != IDLE) && !rst;

  // State register and burst bookkeeping. The read output register is also cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_adr  <= '0;
      len      <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      cur_adr  <= cur_adr_nxt;
      len      <= len_nxt;
      cnt      <= cnt_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
    end
  end

  // Next-state logic and the combinational handshake outputs. Reset masks every strobe.
  always_comb begin
    state_nxt    = state;
    cur_adr_nxt  = cur_adr;
    len_nxt      = len;
    cnt_nxt      = cnt;
    rd_valid_nxt = rd_valid;
    rd_data_nxt  = rd_data;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_w        = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_adr_nxt = cmd_adr;
          len_nxt     = cmd_len;
          cnt_nxt     = '0;
          state_nxt   = cmd_rd ? RD_REQ : WR;
        end
      end

      WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_w       = 1'b1;
          cur_adr_nxt = cur_adr + ADR_W'(1);
          cnt_nxt     = cnt + ADR_W'(1);
          if (cnt == len) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      // The address is already presented. The RAM registers its output at this edge.
      RD_REQ: state_nxt = RD_CAP;

      RD_CAP: begin
        rd_data_nxt  = ram_dout;
        rd_valid_nxt = 1'b1;
        state_nxt    = RD_OUT;
      end

      RD_OUT: begin
        if (rd_ready) begin
          rd_valid_nxt = 1'b0;
          if (cnt == len) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            cur_adr_nxt = cur_adr + ADR_W'(1);
            cnt_nxt     = cnt + ADR_W'(1);
            state_nxt   = RD_REQ;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      ram_w     = 1'b0;
      done      = 1'b0;
    end
  end

endmodule
